// File: rtl/count_arb_pkg.sv
// rtl/count_arb_pkg.sv - shared types and helpers for count_arbiter
// Contents: FSM state enum, index-width helpers, round-robin pick and one-hot encoder.
package count_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Helpers are sized for the largest supported requester count so that
  // one function body serves every NREQ.
  localparam int unsigned MAX_NREQ  = 8;
  localparam int unsigned MAX_IDX_W = $clog2(MAX_NREQ);
  localparam int unsigned NREQ_W    = MAX_IDX_W + 1;

  // Requester index width ($clog2(NREQ)), kept at least 1 bit wide.
  function automatic int unsigned idx_w(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // One-hot pick of the first requester at or after ptr, wrapping at nreq.
  // Scanning from the farthest offset down lets the nearest one win.
  function automatic logic [MAX_NREQ-1:0] rr_pick(
    input logic [MAX_NREQ-1:0]  req_v,
    input logic [MAX_IDX_W-1:0] ptr,
    input logic [NREQ_W-1:0]    nreq
  );
    logic [MAX_NREQ-1:0] pick;
    logic [NREQ_W-1:0]   idx;
    pick = '0;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + NREQ_W'(k);
      if (idx >= nreq) idx = idx - nreq;
      if ((k < int'(nreq)) && req_v[idx[MAX_IDX_W-1:0]]) begin
        pick = '0;
        pick[idx[MAX_IDX_W-1:0]] = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [MAX_IDX_W-1:0] oh2idx(input logic [MAX_NREQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      if (oh[k]) idx = MAX_IDX_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/count_arbiter_counter.sv
// rtl/count_arbiter_counter.sv - modulo-2^CNT_W event counter with wrap pulse
// Ports: clk, reset (async, active-high), inc (advance by one),
//        cnt (current value), wrap (pulse in the cycle cnt becomes 0 by wrapping).
module mod_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q;
  logic             wrap_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= inc && (cnt_q == '1);
      if (inc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/count_arbiter.sv
// rtl/count_arbiter.sv - round-robin arbiter sequencing bursts on a shared counter
// Optional macro: COUNT_ARB_PAUSE_EN adds input hold (freezes a burst in RUN).
// Ports: clk, reset (async, active-high), req[NREQ], len[NREQ*LEN_W],
//        gnt[NREQ] (one-hot), busy, done (pulse), done_id, cnt_out, wrap (pulse).
module count_arbiter
  import count_arb_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int CNT_W = 2,
  parameter  int LEN_W = 3,
  localparam int IDX_W = idx_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef COUNT_ARB_PAUSE_EN
  input  logic                  hold,
`endif
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      done_id,
  output logic [CNT_W-1:0]      cnt_out,
  output logic                  wrap
);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [IDX_W-1:0]    done_id_q, done_id_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                run_adv;
  logic                inc;
  logic [MAX_NREQ-1:0] pick_oh;
  logic [IDX_W-1:0]    pick_idx;

`ifdef COUNT_ARB_PAUSE_EN
  assign run_adv = ~hold;
`else
  assign run_adv = 1'b1;
`endif

  assign pick_oh  = rr_pick(MAX_NREQ'(req), MAX_IDX_W'(ptr_q), NREQ_W'(NREQ));
  assign pick_idx = IDX_W'(oh2idx(pick_oh));

  // The counter advances exactly on the cycles RUN consumes one unit of rem_q.
  assign inc = (state_q == ST_RUN) && run_adv;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    rem_d     = rem_q;
    done_id_d = done_id_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_d   = pick_idx;
          rem_d   = len[int'(pick_idx)*LEN_W +: LEN_W];
          gnt_d   = pick_oh[NREQ-1:0];
          busy_d  = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (rem_q == '0) begin
          // Zero-length burst: no increment, straight to completion.
          state_d   = ST_DONE;
          done_d    = 1'b1;
          done_id_d = win_q;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (run_adv) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            done_id_d = win_q;
          end
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      rem_q     <= '0;
      done_id_q <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      rem_q     <= rem_d;
      done_id_q <= done_id_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  mod_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .cnt   (cnt_out),
    .wrap  (wrap)
  );

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_count_arbiter.sv
// tb/tb_count_arbiter.sv - directed self-checking bench for count_arbiter
`timescale 1ns/1ps
module tb_count_arbiter;

  localparam int NREQ  = 2;
  localparam int CNT_W = 2;
  localparam int LEN_W = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [0:0]            done_id;
  logic [CNT_W-1:0]      cnt_out;
  logic                  wrap;
`ifdef COUNT_ARB_PAUSE_EN
  logic                  hold;
`endif

  int checks   = 0;
  int errors   = 0;
  int wrap_cnt = 0;
  int cyc      = 0;
  int w0;
  int last;
  int gstart;
  bit ok;

  count_arbiter #(
    .NREQ  (NREQ),
    .CNT_W (CNT_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef COUNT_ARB_PAUSE_EN
    .hold    (hold),
`endif
    .req     (req),
    .len     (len),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .cnt_out (cnt_out),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (wrap) wrap_cnt = wrap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    req   = '0;
    len   = '0;
    reset = 1'b1;
`ifdef COUNT_ARB_PAUSE_EN
    hold  = 1'b0;
`endif
    step();
    step();
    check("rst_gnt",     gnt,     0);
    check("rst_busy",    busy,    0);
    check("rst_done",    done,    0);
    check("rst_done_id", done_id, 0);
    check("rst_cnt",     cnt_out, 0);
    check("rst_wrap",    wrap,    0);
    reset = 1'b0;

    // Asynchronous reset in the middle of a 5-increment burst.
    req = 2'b01; len = {3'd0, 3'd5};
    step();
    check("mid_gnt", gnt, 2'b01);
    req = '0;
    step(); step(); step();
    check("mid_cnt_pre", cnt_out, 2);
    #2 reset = 1'b1;
    #1;
    check("mid_async_gnt",  gnt,     0);
    check("mid_async_busy", busy,    0);
    check("mid_async_cnt",  cnt_out, 0);
    check("mid_async_done", done,    0);
    step();
    reset = 1'b0;
    step();
    check("mid_post_cnt",  cnt_out, 0);
    check("mid_post_busy", busy,    0);

    // Single 3-increment burst; len change during RUN is ignored.
    w0  = wrap_cnt;
    req = 2'b01; len = {3'd0, 3'd3};
    step();
    check("b1_gnt",  gnt,  2'b01);
    check("b1_busy", busy, 1);
    req = '0;
    step();
    check("b1_cnt0", cnt_out, 0);
    len = {3'd0, 3'd7};
    step(); check("b1_cnt1", cnt_out, 1);
    step(); check("b1_cnt2", cnt_out, 2);
    step();
    check("b1_cnt3",    cnt_out, 3);
    check("b1_done",    done,    1);
    check("b1_done_id", done_id, 0);
    check("b1_gnt_dn",  gnt,     2'b01);
    step();
    check("b1_done_off", done, 0);
    check("b1_gnt_off",  gnt,  0);
    check("b1_busy_off", busy, 0);
    check("b1_nowrap",   wrap_cnt - w0, 0);

    // Burst of 2 from cnt_out=3 wraps once.
    w0  = wrap_cnt;
    req = 2'b10; len = {3'd2, 3'd0};
    step();
    check("wr_gnt", gnt, 2'b10);
    req = '0;
    step();
    step();
    check("wr_cnt0", cnt_out, 0);
    check("wr_wrap", wrap,    1);
    step();
    check("wr_cnt1",    cnt_out, 1);
    check("wr_wrap_lo", wrap,    0);
    check("wr_done",    done,    1);
    check("wr_done_id", done_id, 1);
    check("wr_wrap_n",  wrap_cnt - w0, 1);

    // Both requesters held, len=1 each: alternation with a 4-cycle period.
    w0   = wrap_cnt;
    last = 0;
    req  = 2'b11; len = {3'd1, 3'd1};
    for (int b = 0; b < 4; b++) begin
      wait_done(12, ok);
      check("rr_seen", ok, 1);
      check("rr_id",   done_id, b % 2);
      check("rr_gnt",  gnt, (b % 2) ? 2 : 1);
      if (b > 0) check("rr_period", cyc - last, 4);
      last = cyc;
      if (b == 3) req = '0;
    end
    step();
    check("rr_gap_gnt", gnt,     0);
    check("rr_cnt",     cnt_out, 1);
    check("rr_wrap_n",  wrap_cnt - w0, 1);

    // Zero-length burst: GRANT and DONE only, counter untouched.
    req = 2'b10; len = {3'd0, 3'd0};
    step();
    check("z_gnt", gnt, 2'b10);
    req = '0;
    step();
    check("z_done",    done,    1);
    check("z_done_id", done_id, 1);
    check("z_gnt_dn",  gnt,     2'b10);
    step();
    check("z_gnt_off", gnt,     0);
    check("z_busy",    busy,    0);
    check("z_cnt",     cnt_out, 1);

`ifdef COUNT_ARB_PAUSE_EN
    // Burst of 4 paused for 3 cycles in RUN.
    req = 2'b01; len = {3'd0, 3'd4};
    step();
    gstart = cyc;
    check("p_gnt", gnt, 2'b01);
    req = '0;
    step();
    step(); check("p_cnt2", cnt_out, 2);
    step(); check("p_cnt3", cnt_out, 3);
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      step();
      check("p_hold_cnt",  cnt_out, 3);
      check("p_hold_gnt",  gnt,     2'b01);
      check("p_hold_wrap", wrap,    0);
      check("p_hold_done", done,    0);
    end
    hold = 1'b0;
    step();
    check("p_cnt0", cnt_out, 0);
    check("p_wrap", wrap,    1);
    step();
    check("p_cnt1",    cnt_out, 1);
    check("p_done",    done,    1);
    check("p_latency", cyc - gstart, 8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
